hazard_stall_unit: RTL and testbench

- Stall-side counterpart of the pipeline's EX-stage forwarding logic. It detects the hazards that forwarding cannot cover (load-use, and branches resolved in ID whose operands are not ready yet) and inserts the required bubbles.
- A small FSM holds multi-cycle stalls, and the block issues the IF/ID flush for taken branches and jumps.
- Sits in ID and drives PC write-enable, IF/ID write-enable, the ID/EX control-zeroing mux and the IF/ID flush.

---
 rtl/hazard_stall_unit.sv | 107 ++++++++++
 tb/tb_hazard_stall_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Stall control for hazards that forwarding cannot resolve, plus the IF/ID flush for taken branches and jumps.
// Define HAZARD_PERF_CNT_EN to build the saturating stall_cycles counter; otherwise stall_cycles reads 0.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dst,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_is_jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t     state, state_next;
    logic [1:0] rem, rem_next;
    logic       match_ex, match_mem;
    logic       need_two, need_one;
    logic       stall;

    // $zero is never a real producer, so it can never cause a stall.
    always_comb begin
        match_ex  = (id_ex_dst != 5'd0) &&
                    ((id_ex_dst == if_id_rs) || (id_uses_rt && (id_ex_dst == if_id_rt)));
        match_mem = (ex_mem_dst != 5'd0) &&
                    ((ex_mem_dst == if_id_rs) || (id_uses_rt && (ex_mem_dst == if_id_rt)));
        need_two  = id_is_branch && id_ex_mem_read && match_ex;
        need_one  = (!id_is_branch && id_ex_mem_read && match_ex) ||
                    (id_is_branch && id_ex_reg_write && !id_ex_mem_read && match_ex) ||
                    (id_is_branch && ex_mem_mem_read && match_mem);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= 2'd0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Only the two-cycle case needs to remember anything; single stalls re-detect from live inputs.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        case (state)
            IDLE: begin
                if (need_two) begin
                    state_next = STALL;
                    rem_next   = 2'd1;
                end
            end
            STALL: begin
                if (rem <= 2'd1) begin
                    state_next = IDLE;
                    rem_next   = 2'd0;
                end else begin
                    rem_next = rem - 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                rem_next   = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall        = (state == STALL) || ((state == IDLE) && (need_two || need_one));
        pc_write     = !stall;
        if_id_write  = !stall;
        id_ex_bubble = stall;
        if_id_flush  = !stall && (id_is_jump || (id_is_branch && id_branch_taken));
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturates rather than wrapping so a long run never reports a misleadingly small count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (stall && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a 16-bit-counter instance and a 2-bit-counter instance share all stimulus.
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic [4:0]  id_ex_dst, ex_mem_dst, if_id_rs, if_id_rt;
    logic        id_uses_rt, id_is_branch, id_branch_taken, id_is_jump;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic        pc_write2, if_id_write2, id_ex_bubble2, if_id_flush2;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_cycles2;
    logic        perf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .id_ex_dst(id_ex_dst),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dst(ex_mem_dst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .stall_cycles(stall_cycles)
    );

    hazard_stall_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .id_ex_dst(id_ex_dst),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dst(ex_mem_dst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .id_ex_bubble(id_ex_bubble2),
        .if_id_flush(if_id_flush2), .stall_cycles(stall_cycles2)
    );

    task automatic clear_inputs();
        id_ex_mem_read  = 1'b0; id_ex_reg_write = 1'b0; id_ex_dst  = 5'd0;
        ex_mem_mem_read = 1'b0; ex_mem_dst      = 5'd0;
        if_id_rs = 5'd0; if_id_rt = 5'd0; id_uses_rt = 1'b0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0; id_is_jump = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk); #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 1100", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_counter got %0d/%0d expected 0/0", stall_cycles, stall_cycles2);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_dst = 5'd8; if_id_rs = 5'd8;
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL load_use_stall got %b expected 0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL load_use_release got %b expected 110", {pc_write, if_id_write, id_ex_bubble});
        end
        checks++;
        if (stall_cycles !== (perf ? 16'd1 : 16'd0) || stall_cycles2 !== (perf ? 2'd1 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL load_use_count got %0d/%0d expected %0d", stall_cycles, stall_cycles2, perf ? 1 : 0);
        end
    endtask

    task automatic test_branch_after_load();
        @(negedge clk);
        id_is_branch = 1'b1; id_uses_rt = 1'b1; if_id_rt = 5'd9; if_id_rs = 5'd3;
        id_ex_mem_read = 1'b1; id_ex_dst = 5'd9;
        #1;
        checks++;
        if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_load_cycle1 got pc_write=%b bubble=%b expected 0/1", pc_write, id_ex_bubble);
        end
        @(negedge clk);
        id_branch_taken = 1'b1;
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL branch_load_cycle2 got %b expected 0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        @(negedge clk);
        id_ex_mem_read = 1'b0; id_ex_dst = 5'd0;
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL branch_load_release got %b expected 1101", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        checks++;
        if (stall_cycles !== (perf ? 16'd3 : 16'd0) || stall_cycles2 !== (perf ? 2'd3 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL branch_load_count got %0d/%0d expected %0d", stall_cycles, stall_cycles2, perf ? 3 : 0);
        end
        clear_inputs();
    endtask

    task automatic test_branch_after_alu();
        @(negedge clk);
        id_ex_reg_write = 1'b1; id_ex_dst = 5'd5;
        id_is_branch = 1'b1; id_uses_rt = 1'b1; if_id_rs = 5'd5; if_id_rt = 5'd6;
        #1;
        checks++;
        if ({pc_write, id_ex_bubble, if_id_flush} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL branch_alu_stall got %b expected 010", {pc_write, id_ex_bubble, if_id_flush});
        end
        @(negedge clk);
        id_ex_reg_write = 1'b0; id_ex_dst = 5'd0; id_branch_taken = 1'b1;
        #1;
        checks++;
        if ({pc_write, id_ex_bubble, if_id_flush} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL branch_alu_flush got %b expected 101", {pc_write, id_ex_bubble, if_id_flush});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (if_id_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_one_cycle got %b expected 0", if_id_flush);
        end
        checks++;
        if (stall_cycles !== (perf ? 16'd4 : 16'd0) || stall_cycles2 !== (perf ? 2'd3 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL branch_alu_count got %0d/%0d expected %0d/%0d", stall_cycles, stall_cycles2, perf ? 4 : 0, perf ? 3 : 0);
        end
    endtask

    task automatic test_branch_mem_load_and_jump();
        @(negedge clk);
        ex_mem_mem_read = 1'b1; ex_mem_dst = 5'd4;
        id_is_branch = 1'b1; id_uses_rt = 1'b1; if_id_rs = 5'd4; if_id_rt = 5'd2;
        #1;
        checks++;
        if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_mem_load got bubble=%b pc_write=%b expected 1/0", id_ex_bubble, pc_write);
        end
        @(negedge clk);
        clear_inputs();
        id_is_jump = 1'b1;
        #1;
        checks++;
        if ({pc_write, id_ex_bubble, if_id_flush} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL jump_flush got %b expected 101", {pc_write, id_ex_bubble, if_id_flush});
        end
        clear_inputs();
    endtask

    task automatic test_zero_dst();
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_dst = 5'd0; if_id_rs = 5'd0;
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL zero_dst got %b expected 1100", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        // rt matches but the instruction does not read rt
        id_ex_dst = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        checks++;
        if (id_ex_bubble !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unused_rt got bubble=%b expected 0", id_ex_bubble);
        end
        clear_inputs();
    endtask

    task automatic test_counter_saturation();
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_dst = 5'd12; if_id_rs = 5'd12;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (id_ex_bubble !== 1'b1) begin
                errors++;
                $display("[TB] FAIL held_stall[%0d] got bubble=%b expected 1", i, id_ex_bubble);
            end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== (perf ? 16'd11 : 16'd0)) begin
            errors++;
            $display("[TB] FAIL count16 got %0d expected %0d", stall_cycles, perf ? 11 : 0);
        end
        @(negedge clk); #1;
        checks++;
        if (stall_cycles2 !== (perf ? 2'd3 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL count2_saturated got %0d expected %0d", stall_cycles2, perf ? 3 : 0);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        id_is_branch = 1'b1; id_uses_rt = 1'b1; if_id_rs = 5'd10; id_ex_mem_read = 1'b1; id_ex_dst = 5'd10;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_state_holds got bubble=%b pc_write=%b expected 1/0", id_ex_bubble, pc_write);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs got %b expected 1100", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_counter got %0d/%0d expected 0/0", stall_cycles, stall_cycles2);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (pc_write !== 1'b1 || stall_cycles !== 16'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got pc_write=%b count=%0d expected 1/0", pc_write, stall_cycles);
        end
    endtask

    initial begin
        perf = PERF;
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_branch_after_alu();
        test_branch_mem_load_and_jump();
        test_zero_dst();
        test_counter_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
